alu_bist: RTL and testbench

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_bist_if.sv | 10 +
 rtl/alu_bist_lfsr32.sv | 19 +
 rtl/alu_bist.sv | 83 ++++++++
 tb/tb_alu_bist.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and LFSR taps shared by the ALU self-test block.
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;
    function automatic logic [2:0] next_op(logic [2:0] op);
        return op == OP_AND ? OP_OR  :
               op == OP_OR  ? OP_ADD :
               op == OP_ADD ? OP_SUB :
               op == OP_SUB ? OP_SLT : OP_AND;
    endfunction
endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/opcode bus from the self-test block to the ALU under test.
interface alu_bist_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;
    logic        alu_ex;
    modport master (output alu_a, alu_b, alu_op, input alu_z, alu_ex);
    modport slave  (input alu_a, alu_b, alu_op, output alu_z, alu_ex);
endinterface

// File: rtl/alu_bist_lfsr32.sv
// lfsr32: 32-bit right-shifting Galois LFSR with seed load; a zero seed becomes 1.
module lfsr32 import alu_pkg::*; #(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] q
);
    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    logic [31:0] q_q, q_d;
    always_comb q_d = load ? INIT : step ? ({1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_TAPS : 32'h0)) : q_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/alu_bist.sv
// alu_bist: drives pseudo-random operand pairs through five opcodes to an ALU and
// checks each result and zero flag, recording the error count and first failure.
module alu_bist import alu_pkg::*; #(
    parameter int unsigned N_VECTORS = 10,
    parameter logic [31:0] SEED_A    = 32'h1234_5678,
    parameter logic [31:0] SEED_B    = 32'h8765_4321
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    alu_bist_if.master      alu,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic [15:0]     fail_vec,
    output logic [2:0]      fail_op
);
    localparam logic [15:0] LAST_VEC = 16'(N_VECTORS - 1);
    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d, fail_op_q, fail_op_d;
    logic [15:0] vec_q, vec_d, err_q, err_d, fail_vec_q, fail_vec_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [31:0] a_q, b_q, exp_z;
    logic        accept, mismatch, step, finish;
    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst_n(rst_n), .load(accept), .step(step), .q(a_q));
    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst_n(rst_n), .load(accept), .step(step), .q(b_q));
    always_comb begin
        accept   = (state_q == S_IDLE || state_q == S_DONE) && start;
        exp_z    = op_q == OP_AND ? a_q & b_q :
                   op_q == OP_OR  ? a_q | b_q :
                   op_q == OP_ADD ? a_q + b_q :
                   op_q == OP_SUB ? a_q + ~b_q + 32'd1 :
                   {31'b0, $signed(a_q) < $signed(b_q)};
        mismatch = state_q == S_CHECK && (alu.alu_z != exp_z || alu.alu_ex != (exp_z == 32'h0));
        step     = state_q == S_CHECK && op_q == OP_SLT;
        finish   = step && vec_q == LAST_VEC;
        state_d  = accept ? S_DRIVE :
                   state_q == S_DRIVE ? S_CHECK :
                   state_q == S_CHECK ? (finish ? S_DONE : S_DRIVE) : state_q;
        op_d     = accept ? OP_AND : state_q == S_CHECK ? next_op(op_q) : op_q;
        vec_d    = accept ? 16'h0 : step ? vec_q + 16'd1 : vec_q;
        err_d    = accept ? 16'h0 : (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        // only the first mismatch of a run is recorded
        fail_vec_d = accept ? 16'h0 : (mismatch && err_q == 16'h0) ? vec_q : fail_vec_q;
        fail_op_d  = accept ? 3'b000 : (mismatch && err_q == 16'h0) ? op_q : fail_op_q;
        busy_d   = state_d == S_DRIVE || state_d == S_CHECK;
        done_d   = state_d == S_DONE;
        pass_d   = state_d == S_DONE && err_d == 16'h0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            vec_q      <= '0;
            err_q      <= '0;
            fail_vec_q <= '0;
            fail_op_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            fail_vec_q <= fail_vec_d;
            fail_op_q  <= fail_op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end
    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_op = op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fail_vec_q;
    assign fail_op    = fail_op_q;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: cycle model of the default-configuration BIST plus directed literal checks.
module tb_alu_bist;
    import alu_pkg::*;
    localparam logic [31:0] SA = 32'h1234_5678;
    localparam logic [31:0] SB = 32'h8765_4321;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   fault0 = 0;
    int   n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;

    alu_bist_if bus0(), bus1(), bus2();
    logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err0, fv0, err1, fv1, err2, fv2;
    logic [2:0] fo0, fo1, fo2;

    function automatic logic [31:0] ref_z(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction
    function automatic logic [31:0] lfsr_adv(logic [31:0] s, int n);
        logic [31:0] x;
        x = (s == 32'h0) ? 32'h1 : s;
        repeat (n) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
    endfunction
    function automatic logic [31:0] alu0_z(logic [31:0] a, logic [31:0] b, logic [2:0] op, int f);
        return (f == 1 && op == 3'b000) ? (a | b) : ref_z(a, b, op);
    endfunction

    assign bus0.alu_z  = alu0_z(bus0.alu_a, bus0.alu_b, bus0.alu_op, fault0);
    assign bus0.alu_ex = bus0.alu_z == 32'h0;
    assign bus1.alu_z  = ref_z(bus1.alu_a, bus1.alu_b, bus1.alu_op);
    assign bus1.alu_ex = bus1.alu_z == 32'h0;
    assign bus2.alu_z  = ref_z(bus2.alu_a, bus2.alu_b, bus2.alu_op);
    assign bus2.alu_ex = 1'b0;

    alu_bist dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .alu(bus0), .busy(busy0), .done(done0),
                   .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_op(fo0));
    alu_bist #(.N_VECTORS(1), .SEED_A(32'h8000_0000), .SEED_B(32'h1)) dut1 (.clk(clk), .rst_n(rst_n),
                   .start(start1), .alu(bus1), .busy(busy1), .done(done1), .pass(pass1),
                   .err_count(err1), .fail_vec(fv1), .fail_op(fo1));
    alu_bist #(.N_VECTORS(1), .SEED_A(32'h5), .SEED_B(32'h5)) dut2 (.clk(clk), .rst_n(rst_n),
                   .start(start2), .alu(bus2), .busy(busy2), .done(done2), .pass(pass2),
                   .err_count(err2), .fail_vec(fv2), .fail_op(fo2));

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Model of dut0: run k counts cycles since start; odd k are result checks.
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    bit m_run = 0, m_done = 0;
    int k = 0, m_err = 0, m_fv = 0, m_fo = 0;
    logic [31:0] ma, mb, mz, mg;
    logic [2:0]  mop;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_err = 0; m_fv = 0; m_fo = 0; k = 0;
        end else if (!m_run && start0) begin
            m_run = 1; m_done = 0; m_err = 0; m_fv = 0; m_fo = 0; k = 0;
        end else if (m_run) begin
            if (k % 2 == 1) begin
                ma = lfsr_adv(SA, k / 10);
                mb = lfsr_adv(SB, k / 10);
                mop = ops[(k % 10) / 2];
                mz = alu0_z(ma, mb, mop, fault0);
                mg = ref_z(ma, mb, mop);
                if (mz != mg) begin
                    if (m_err == 0) begin m_fv = k / 10; m_fo = int'(mop); end
                    if (m_err < 65535) m_err++;
                end
            end
            k++;
            if (k == 100) begin m_run = 0; m_done = 1; end
        end
    end

    always @(negedge clk) begin
        if (!rst_n)
            chk("reset_outputs", 128'({busy0, done0, pass0, err0, fv0, fo0, bus0.alu_a, bus0.alu_b, bus0.alu_op}), 128'h0);
        else begin
            chk("busy", 128'(busy0), 128'(m_run));
            chk("done", 128'(done0), 128'(m_done));
            chk("pass", 128'(pass0), 128'(m_done && m_err == 0));
            chk("err_count", 128'(err0), 128'(m_err));
            chk("fail_vec", 128'(fv0), 128'(m_fv));
            chk("fail_op", 128'(fo0), 128'(m_fo));
            if (m_run)
                chk("operands", 128'({bus0.alu_a, bus0.alu_b, bus0.alu_op}),
                    128'({lfsr_adv(SA, k / 10), lfsr_adv(SB, k / 10), ops[(k % 10) / 2]}));
        end
    end

    task automatic run0(output int cyc);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (busy0 && cyc < 2000) begin cyc++; @(negedge clk); end
    endtask

    int cyc, t;
    logic [31:0] z_add, z_sub, z_slt;
    initial begin
        repeat (2) @(negedge clk);
        chk("reset_literal", 128'({busy0, done0, pass0, err0}), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run0(cyc);
        chk("busy_cycles", 128'(cyc), 128'd100);
        chk("good_run", 128'({done0, pass0, err0}), 128'({1'b1, 1'b1, 16'd0}));
        fault0 = 1;
        run0(cyc);
        chk("or_fault_result", 128'({pass0, err0, fv0, fo0}), 128'({1'b0, 16'd10, 16'd0, 3'b000}));
        chk("model_err_pin", 128'(m_err), 128'd10);
        fault0 = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (36) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset", 128'({busy0, done0, pass0, err0, fv0, fo0}), 128'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 128'({busy0, done0}), 128'h0);
        run0(cyc);
        chk("rerun_cycles", 128'(cyc), 128'd100);
        chk("rerun_pass", 128'({done0, pass0}), 128'b11);
        start0 = 1'b1;
        @(negedge clk);
        t = 0;
        while (busy0 && t < 2000) begin t++; @(negedge clk); end
        chk("held_start_cycles", 128'(t), 128'd100);
        chk("held_start_done", 128'({busy0, done0}), 128'b01);
        @(negedge clk);
        chk("held_start_restart", 128'({busy0, done0}), 128'b10);
        start0 = 1'b0;
        t = 0;
        while (!done0 && t < 2000) begin t++; @(negedge clk); end
        chk("held_start_second", 128'({done0, pass0}), 128'b11);
        z_add = 32'hDEAD_BEEF; z_sub = 32'hDEAD_BEEF; z_slt = 32'hDEAD_BEEF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (!done1 && t < 100) begin
            if (bus1.alu_op == 3'b010) z_add = bus1.alu_z;
            if (bus1.alu_op == 3'b110) z_sub = bus1.alu_z;
            if (bus1.alu_op == 3'b111) z_slt = bus1.alu_z;
            t++;
            @(negedge clk);
        end
        chk("seed_add", 128'(z_add), 128'h8000_0001);
        chk("seed_sub", 128'(z_sub), 128'h7FFF_FFFF);
        chk("seed_slt", 128'(z_slt), 128'h1);
        chk("seed_pass", 128'({done1, pass1, err1}), 128'({1'b1, 1'b1, 16'd0}));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t = 0;
        while (!done2 && t < 100) begin t++; @(negedge clk); end
        chk("ex_stuck_result", 128'({done2, pass2, err2, fv2, fo2}), 128'({1'b1, 1'b0, 16'd2, 16'd0, 3'b110}));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
